mux_nx1_rr: RTL
===============

Name: mux_nx1_rr

Overview:
Parametrised registered N-to-1 multiplexer, the successor to the 2:1 registered mux. It adds valid/ready handshaking on every input and the output, and two selection modes: explicit select and round-robin arbitration. It sits between N producer channels and one consumer, and provides one output register stage with full backpressure.

Parameters:
N, 4, number of input channels (N >= 2)
WIDTH, 8, data width per channel
SELW, $clog2(N), width of the select and channel-id fields (derived, not overridden)

Ports:
clk  input  1  clock; all logic on rising edge
reset  input  1  synchronous, active-high reset
in_data  input  N*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH]
in_valid  input  N  per-channel data valid
in_ready  output  N  per-channel accept; combinational
sel  input  SELW  channel index used when mode=0
mode  input  1  0 = explicit select, 1 = round-robin
out_data  output  WIDTH  registered selected data
out_valid  output  1  registered; out_data/out_ch hold a word
out_ready  input  1  consumer accept
out_ch  output  SELW  registered index of the channel that supplied out_data

Behaviour:
- Reset (sync, reset=1 at posedge): out_valid=0, out_data=0, out_ch=0, rr_ptr=N-1. While reset is high, in_ready=0. Reset mid-transfer drops the held word.
- load_en = !out_valid || out_ready. The register accepts a new word in the same cycle the old one drains, so throughput is 1 word/cycle.
- Grant, combinational:
  - mode=0: grant=sel, grant_vld = in_valid[sel] && sel<N. If sel>=N (N not a power of 2), there is no grant.
  - mode=1: search channels rr_ptr+1, rr_ptr+2, ... modulo N. The first channel with in_valid=1 wins. grant_vld = |in_valid.
- in_ready[i] = !reset && load_en && grant_vld && grant==i. At most one bit is set; in_ready does not depend on in_valid of non-granted channels in mode 0.
- Transfer on channel i = in_valid[i] && in_ready[i]. At the next posedge: out_data <= in_data[i], out_ch <= i, out_valid <= 1. Latency is 1 cycle, input to output.
- If load_en=1 and no grant, then out_valid <= 0 at the next posedge.
- If load_en=0 (out_valid=1, out_ready=0), out_data, out_ch and out_valid hold stable and all in_ready=0.
- rr_ptr <= grant only on a transfer in mode=1. It is unchanged on mode=0 transfers and on idle cycles.
- Mode or sel change takes effect in the same cycle for the grant. rr_ptr is retained across mode switches.
- Wrap-around: with rr_ptr=N-1, the search starts at channel 0.
- A single requester is always granted, regardless of rr_ptr.
- No combinational path from in_data to out_data.
- in_ready depends combinationally on out_ready.

Test Plan:
- Reset: hold reset=1 for 3 cycles with all in_valid=1 -> in_ready=0, out_valid=0, out_data=0, out_ch=0. After release, mode=1: the first word comes from channel 0.
- Explicit select (mode=0, N=4, WIDTH=8): in_data ch0..3 = 0x10, 0x21, 0x32, 0x43, all valid, out_ready=1, sel=2 -> in_ready=4'b0100. One cycle later out_data=0x32, out_ch=2, out_valid=1. With sel=2 and in_valid[2]=0 -> in_ready=0, and out_valid drops next cycle.
- Round-robin fairness: mode=1, all 4 valid continuously, out_ready=1 -> out_ch sequence 0,1,2,3,0,1 on consecutive cycles, out_valid=1 every cycle.
- Sparse round-robin and wrap: after a grant to ch3, only ch1 and ch3 valid -> next grants ch1, ch3, ch1. Drive only ch2 valid -> granted every cycle.
- Backpressure: mode=1, stream from ch0 with out_ready=0 for 5 cycles -> out_data/out_ch frozen, in_ready=0, rr_ptr unchanged. Raise out_ready -> drain and reload in the same cycle, with no lost or duplicated word (scoreboard counts match).
- Mid-operation reset and mode switch: reset asserted while out_valid=1 -> next cycle out_valid=0, rr_ptr=N-1. Switch mode 1->0 with sel=3 -> ch3 granted immediately. Switch back -> round-robin resumes from the retained pointer.

Source files
------------

// File: rtl/mux_nx1_rr.sv
// rtl/mux_nx1_rr.sv - registered N:1 mux with valid/ready, explicit-select and round-robin modes
module mux_nx1_rr #(
  parameter int N     = 4,
  parameter int WIDTH = 8,
  parameter int SELW  = $clog2(N)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N*WIDTH-1:0]   in_data,
  input  logic [N-1:0]         in_valid,
  output logic [N-1:0]         in_ready,
  input  logic [SELW-1:0]      sel,
  input  logic                 mode,
  output logic [WIDTH-1:0]     out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [SELW-1:0]      out_ch
);

  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             out_valid_q, out_valid_d;
  logic [SELW-1:0]  out_ch_q, out_ch_d;
  logic [SELW-1:0]  rr_ptr_q, rr_ptr_d;

  logic             load_en;
  logic             xfer;
  logic [SELW-1:0]  grant;
  logic             grant_vld;
  logic [WIDTH-1:0] grant_data;
  int               idx;

  assign load_en = !out_valid_q || out_ready;

  // Round-robin: walk k = N..1 so the smallest offset from rr_ptr wins.
  always_comb begin
    grant     = '0;
    grant_vld = 1'b0;
    idx       = 0;
    if (!mode) begin
      grant = sel;
      for (int i = 0; i < N; i++) begin
        if (sel == SELW'(i)) grant_vld = in_valid[i];
      end
    end else begin
      for (int k = N; k >= 1; k--) begin
        idx = (int'(rr_ptr_q) + k) % N;
        if (in_valid[idx]) begin
          grant     = SELW'(idx);
          grant_vld = 1'b1;
        end
      end
    end
  end

  always_comb begin
    in_ready   = '0;
    grant_data = '0;
    for (int i = 0; i < N; i++) begin
      if (grant == SELW'(i)) begin
        grant_data  = in_data[i*WIDTH +: WIDTH];
        in_ready[i] = !reset && load_en && grant_vld;
      end
    end
  end

  assign xfer = !reset && load_en && grant_vld;

  always_comb begin
    out_data_d  = out_data_q;
    out_ch_d    = out_ch_q;
    out_valid_d = out_valid_q;
    rr_ptr_d    = rr_ptr_q;
    if (load_en) begin
      out_valid_d = xfer;
      if (xfer) begin
        out_data_d = grant_data;
        out_ch_d   = grant;
        if (mode) rr_ptr_d = grant;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_data_q  <= '0;
      out_ch_q    <= '0;
      out_valid_q <= 1'b0;
      rr_ptr_q    <= SELW'(N-1);
    end else begin
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
      out_valid_q <= out_valid_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign out_ch    = out_ch_q;

endmodule
